// File: rtl/parallel_serial_if.sv
// Handshake and data bundle between a parallel word source and the serializer.
// The master drives the word and the start request; the slave returns the serial stream and status.
interface parallel_serial_if #(
    parameter int PORT_WIDTH    = 15,
    parameter int EXTRACT_LNGTH = 4
);
    logic [PORT_WIDTH-1:0]    din;
    logic [EXTRACT_LNGTH-1:0] bit_length;
    logic                     load;
    logic                     ready;
    logic                     dout;
    logic                     tx_en;
    logic                     done;

    modport master (
        output din, bit_length, load,
        input  ready, dout, tx_en, done
    );

    modport slave (
        input  din, bit_length, load,
        output ready, dout, tx_en, done
    );
endinterface

// File: rtl/parallel_serial.sv
// Parallel-to-serial transmitter: sends the low bit_length bits of din LSB first,
// framed by tx_en, followed by a one-cycle done pulse with tx_en low.
module parallel_serial #(
    parameter int PORT_WIDTH    = 15,
    parameter int EXTRACT_LNGTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    parallel_serial_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [EXTRACT_LNGTH-1:0] ONE = EXTRACT_LNGTH'(1);

    logic [1:0]               r_state;
    logic [PORT_WIDTH-1:0]    r_shift;
    logic [EXTRACT_LNGTH-1:0] r_cnt;
    logic [EXTRACT_LNGTH-1:0] r_last;
    logic                     r_ready;
    logic                     r_dout;
    logic                     r_tx_en;
    logic                     r_done;

    logic [EXTRACT_LNGTH-1:0] w_eff_len;
    logic                     w_start;

    // Oversized lengths saturate at the word width instead of wrapping.
    function automatic logic [EXTRACT_LNGTH-1:0] clamp_len(input logic [EXTRACT_LNGTH-1:0] len);
        if (int'(len) > PORT_WIDTH)
            return EXTRACT_LNGTH'(PORT_WIDTH);
        return len;
    endfunction

    assign w_eff_len = clamp_len(bus.bit_length);
    assign w_start   = bus.load && (bus.bit_length != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_ready <= 1'b1;
            r_dout  <= 1'b0;
            r_tx_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Bit 0 is launched on the capture edge so it appears one cycle after load.
                    if (w_start) begin
                        r_shift <= bus.din;
                        r_last  <= w_eff_len - ONE;
                        r_cnt   <= '0;
                        r_dout  <= bus.din[0];
                        r_tx_en <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_cnt == r_last) begin
                        r_dout  <= 1'b0;
                        r_tx_en <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + ONE;
                        r_shift <= r_shift >> 1;
                        r_dout  <= r_shift[1];
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_dout  <= 1'b0;
                    r_tx_en <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.dout  = r_dout;
    assign bus.tx_en = r_tx_en;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_parallel_serial.sv
// Scoreboard bench for parallel_serial: stimulus queues expected bits and frame
// lengths; a negedge monitor checks every tx_en bit, every done pulse and frame gaps.
module tb_parallel_serial;
    localparam int PW = 15;
    localparam int EL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parallel_serial_if #(.PORT_WIDTH(PW), .EXTRACT_LNGTH(EL)) bus ();

    parallel_serial #(.PORT_WIDTH(PW), .EXTRACT_LNGTH(EL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    bit exp_bits[$];
    int exp_len[$];

    int seen      = 0;
    int gap       = 0;
    bit gap_chk   = 1'b0;
    bit had_frame = 1'b0;
    bit prev_tx   = 1'b0;
    bit prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [PW-1:0] d, input int len);
        for (int i = 0; i < len; i++) exp_bits.push_back(d[i]);
        exp_len.push_back(len);
    endtask

    task automatic send(input logic [PW-1:0] d, input logic [EL-1:0] len);
        bus.din        = d;
        bus.bit_length = len;
        bus.load       = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.din  = ~d;
    endtask

    task automatic wait_ready(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready) break;
        end
        if (k == budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got 0 expected 1 within %0d cycles", budget);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (bus.tx_en) begin
            if (exp_bits.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_tx: got tx_en=1 expected no pending bits (t=%0t)", $time);
            end else begin
                chk("dout_bit", {31'd0, bus.dout}, {31'd0, exp_bits.pop_front()});
            end
            seen++;
            if (gap_chk && !prev_tx && had_frame) chk("frame_gap", gap, 2);
            gap       = 0;
            had_frame = 1'b1;
        end else begin
            gap++;
        end
        if (bus.done) begin
            chk("done_outs", {29'd0, bus.tx_en, bus.ready, bus.dout}, 32'd0);
            if (exp_len.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no frame pending (t=%0t)", $time);
            end else begin
                chk("frame_len", seen, exp_len.pop_front());
            end
            seen = 0;
        end
        if (prev_done && !rst) chk("ready_after_done", {31'd0, bus.ready}, 32'd1);
        prev_done = bus.done;
        prev_tx   = bus.tx_en;
        if (rst) seen = 0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h30[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [PW-1:0] d35[4] = '{15'h1235, 15'h4563, 15'h0F0E, 15'h2221};
        logic [PW-1:0] rd;
        logic [EL-1:0] rl;

        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.din        = '0;
        bus.bit_length = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_tx_en", {31'd0, bus.tx_en}, 32'd0);
        chk("rst_dout",  {31'd0, bus.dout},  32'd0);
        chk("rst_done",  {31'd0, bus.done},  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full-width frame with hand-listed bit sequence
        foreach (h30[i]) exp_bits.push_back(h30[i]);
        exp_len.push_back(15);
        send(15'h2AB5, 4'd15);
        wait_ready(40);

        push_frame(15'h000B, 4);
        send(15'h000B, 4'd4);
        wait_ready(20);
        repeat (6) @(posedge clk);

        // Zero-length request must be ignored
        #1;
        bus.bit_length = '0;
        bus.din        = 15'h7FFF;
        bus.load       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("zero_len_idle", {28'd0, bus.ready, bus.tx_en, bus.done, bus.dout}, 32'h8);
        end
        @(posedge clk);
        #1 bus.load = 1'b0;

        // Reset in the middle of a 12-bit frame: only bits 0..5 reach the line
        for (int i = 0; i < 6; i++) exp_bits.push_back(1'((15'h5A3C >> i) & 15'h1));
        send(15'h5A3C, 4'd12);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_tx_en", {31'd0, bus.tx_en}, 32'd0);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_done",  {31'd0, bus.done},  32'd0);
        chk("abort_drain", exp_bits.size(), 0);
        push_frame(15'h0F35, 12);
        @(posedge clk);
        #1;
        send(15'h0F35, 4'd12);
        wait_ready(30);

        for (int f = 0; f < 20; f++) begin
            rd = PW'($urandom);
            rl = EL'($urandom_range(1, 15));
            push_frame(rd, int'(rl));
            send(rd, rl);
            wait_ready(30);
        end

        // Load held high with din shuffled mid-frame
        had_frame      = 1'b0;
        gap_chk        = 1'b1;
        bus.bit_length = 4'd3;
        bus.din        = d35[0];
        push_frame(d35[0], 3);
        bus.load = 1'b1;
        @(posedge clk);
        for (int i = 1; i < 4; i++) begin
            #1 bus.din = 15'h0002;
            repeat (3) @(posedge clk);
            #1 bus.din = 15'h7FFC;
            @(posedge clk);
            #1 bus.din = d35[i];
            push_frame(d35[i], 3);
            @(posedge clk);
        end
        #1 bus.load = 1'b0;
        wait_ready(20);
        gap_chk = 1'b0;

        repeat (5) @(posedge clk);
        chk("bits_drained", exp_bits.size(), 0);
        chk("frames_drained", exp_len.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/parallel_serial.md
PARALLEL_SERIAL -- requirements
Module: parallel_serial

Parameters
REQ-001 PORT_WIDTH, default 15: width of the parallel input word.
REQ-002 EXTRACT_LNGTH, default 4: width of the bit_length port.

Interface
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 din  input  PORT_WIDTH  parallel word to transmit, bit 0 first.
REQ-006 bit_length  input  EXTRACT_LNGTH  number of bits to send from din.
REQ-007 load  input  1  start request; sampled only when ready=1.
REQ-008 ready  output  1  high when IDLE and able to accept load.
REQ-009 dout  output  1  serial data bit.
REQ-010 tx_en  output  1  frame enable; high exactly while a valid bit is on dout.
REQ-011 done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-012 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-013 FSM states: IDLE, SEND, DONE. The encoding is free, with a 2-bit state register.
REQ-014 IDLE: ready=1, tx_en=0, dout=0, done=0.
REQ-015 IDLE with load=1 and bit_length!=0: capture din into the shift register, capture the effective length (REQ-016), clear the counter, and go to SEND on the same edge.
REQ-016 Effective length = min(bit_length, PORT_WIDTH). Values above PORT_WIDTH shall be clamped, not wrapped.
REQ-017 IDLE with load=1 and bit_length=0: ignore the request; stay in IDLE; no done pulse.
REQ-018 SEND: ready=0, tx_en=1, dout=captured_word[counter]. The counter increments by 1 each cycle.
REQ-019 Latency: if load is sampled at edge N, bit k (LSB first) shall appear on dout in the cycle after edge N+k, for k = 0 to len-1.
REQ-020 SEND to DONE occurs on the edge after the cycle carrying bit len-1. tx_en is therefore high for exactly len cycles.
REQ-021 DONE: lasts exactly 1 cycle, with tx_en=0, dout=0, done=1, ready=0. It then returns to IDLE.
REQ-022 The tx_en low cycle in DONE is mandatory. It guarantees at least 1 low cycle between frames so the receiver re-arms.
REQ-023 load, din and bit_length changes during SEND or DONE shall be ignored; the captured values govern the frame.
REQ-024 Back-to-back operation: load held high continuously yields frames separated by exactly 2 idle cycles (the DONE cycle plus the IDLE cycle).
REQ-025 The counter is EXTRACT_LNGTH bits wide. It shall never wrap within a frame because the length is at most PORT_WIDTH.
REQ-026 Illegal state encoding: go to IDLE on the next edge with all outputs at their idle values.

Reset
REQ-027 rst=1 at a rising edge: state=IDLE, ready=1, tx_en=0, dout=0, done=0, counter=0, shift register=0.
REQ-028 Reset shall take priority over load and over any state, including mid-frame in SEND. The aborted frame shall produce no done pulse.
REQ-029 An aborted frame leaves tx_en low from the cycle after the reset edge. Downstream receivers see this as the frame ending.

Verification
REQ-030 PORT_WIDTH=15, din=15'h2AB5, bit_length=15, load pulse -> dout carries 1,0,1,0,1,1,0,1,0,1,0,1,0,1,0 over 15 tx_en cycles; then done=1 for 1 cycle; ready=1 on the following cycle.
REQ-031 din=15'h000B, bit_length=4 -> tx_en high for 4 cycles with dout 1,1,0,1; done pulse; no further tx_en.
REQ-032 bit_length=0 with load=1 -> ready stays 1; tx_en, done and dout stay 0 for 20 cycles.
REQ-033 Loopback into the team's serial_parallel receiver (same PORT_WIDTH/EXTRACT_LNGTH, en=tx_en, din=dout) with a random 1000-frame sweep of din and bit_length 1-15 -> the receiver asserts dv_out each frame; its dout equals din masked to the low bit_length bits.
REQ-034 rst asserted at the 6th cycle of a 12-bit frame -> tx_en=0 and ready=1 after that edge; no done pulse; the next load starts a clean frame from bit 0.
REQ-035 load held high, din changed mid-frame, bit_length=3 -> each frame shows the din value sampled at its start; frames are 3 tx_en cycles separated by exactly 2 low cycles.
